// File: rtl/gamepad_pmod_multi.sv
// gamepad_pmod_multi: serial receiver/decoder for 1..4 daisy-chained Gamepad Pmod controllers
// Ports: clk, rst_n (async active-low); pmod_data/pmod_clk/pmod_latch (async serial inputs);
//   buttons/pressed/released [12*NUM_PADS] (pad p at [12p+11:12p], {b,y,sel,start,up,down,left,right,a,x,l,r});
//   is_present [NUM_PADS]; frame_valid, frame_error (strobes); link_ok (good frame within TIMEOUT_CYCLES).
// Option: define GAMEPAD_EVENT_EN to build the pressed/released strobes; otherwise they are tied to 0.
module gamepad_pmod_multi #(
    parameter int NUM_PADS       = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pmod_data,
    input  logic                    pmod_clk,
    input  logic                    pmod_latch,
    output logic [12*NUM_PADS-1:0]  buttons,
    output logic [12*NUM_PADS-1:0]  pressed,
    output logic [12*NUM_PADS-1:0]  released,
    output logic [NUM_PADS-1:0]     is_present,
    output logic                    frame_valid,
    output logic                    frame_error,
    output logic                    link_ok
);
    localparam int W  = 12 * NUM_PADS;
    localparam int CW = $clog2(W + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] FULL = CW'(W);
    localparam logic [CW-1:0] OVF  = CW'(W + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    logic [1:0]          data_s;
    logic [2:0]          clk_s, latch_s;
    logic [W-1:0]        shift_reg, pend_word, new_buttons;
    logic [NUM_PADS-1:0] new_present;
    logic [CW-1:0]       bit_cnt;
    logic [TW-1:0]       wd_cnt, wd_next;
    logic                pend_ok, pend_err, clk_fall, latch_rise, expire;

    // bit [1] is the synchronised value, bit [2] its previous cycle
    assign clk_fall   = clk_s[2] & ~clk_s[1];
    assign latch_rise = latch_s[1] & ~latch_s[2];

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        assign new_present[p]          = pend_word[12*p +: 12] != 12'hFFF;
        assign new_buttons[12*p +: 12] = new_present[p] ? pend_word[12*p +: 12] : 12'h000;
    end

    // a commit restarts the watchdog; expiry fires only on the cycle it first reaches the limit
    assign wd_next = pend_ok ? '0 : (wd_cnt == TMAX ? TMAX : wd_cnt + 1'b1);
    assign expire  = !pend_ok && wd_cnt == TMAX - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_s      <= '0;
            clk_s       <= '0;
            latch_s     <= '0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            pend_word   <= '0;
            pend_ok     <= 1'b0;
            pend_err    <= 1'b0;
            wd_cnt      <= TMAX;
            link_ok     <= 1'b0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            buttons     <= '0;
            is_present  <= '0;
        end else begin
            data_s  <= {data_s[0], pmod_data};
            clk_s   <= {clk_s[1:0], pmod_clk};
            latch_s <= {latch_s[1:0], pmod_latch};
            // latch wins over a coincident shift clock fall; that bit is dropped
            if (latch_rise)
                bit_cnt <= '0;
            else if (clk_fall) begin
                shift_reg <= {shift_reg[W-2:0], data_s[1]};
                bit_cnt   <= bit_cnt == OVF ? OVF : bit_cnt + 1'b1;
            end
            // snapshot the frame so later shifting cannot disturb the commit a cycle on
            pend_ok  <= latch_rise && bit_cnt == FULL;
            pend_err <= latch_rise && bit_cnt != FULL;
            if (latch_rise)
                pend_word <= shift_reg;
            wd_cnt      <= wd_next;
            link_ok     <= wd_next < TMAX;
            frame_valid <= pend_ok;
            frame_error <= pend_err;
            if (pend_ok) begin
                buttons    <= new_buttons;
                is_present <= new_present;
            end else if (expire) begin
                buttons    <= '0;
                is_present <= '0;
            end
        end
    end

`ifdef GAMEPAD_EVENT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed  <= '0;
            released <= '0;
        end else begin
            pressed  <= pend_ok ? new_buttons & ~buttons : '0;
            released <= pend_ok ? ~new_buttons & buttons : expire ? buttons : '0;
        end
    end
`else
    assign pressed  = '0;
    assign released = '0;
`endif
endmodule

// File: tb/tb_gamepad_pmod_multi.sv
// tb_gamepad_pmod_multi: frame-level model check of two gamepad_pmod_multi instances (short and long watchdog)
module tb_gamepad_pmod_multi;
`ifdef GAMEPAD_EVENT_EN
    localparam bit EV = 1'b1;
`else
    localparam bit EV = 1'b0;
`endif
    localparam int TO_A = 100;
    localparam int TO_B = 4000;

    typedef struct {
        int          due;
        bit          ok;
        logic [23:0] word;
    } ev_t;

    logic        clk = 0, rst_n = 0, pmod_data = 0, pmod_clk = 0, pmod_latch = 0;
    logic [23:0] btn [2];
    logic [23:0] pr [2];
    logic [23:0] rl [2];
    logic [1:0]  pres [2];
    logic        fv [2];
    logic        fe [2];
    logic        lk [2];

    logic [23:0] m_btn [2];
    logic [23:0] m_pr [2];
    logic [23:0] m_rl [2];
    logic [1:0]  m_pres [2];
    logic        m_fv [2];
    logic        m_fe [2];
    logic        m_lk [2];
    int          m_last [2];

    ev_t         q [$];
    int          cyc = 0, checks = 0, failures = 0, bits = 0, d = 0, c = 0;
    logic [23:0] sr = 0;

    gamepad_pmod_multi #(.NUM_PADS(2), .TIMEOUT_CYCLES(TO_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .pmod_data(pmod_data), .pmod_clk(pmod_clk), .pmod_latch(pmod_latch),
        .buttons(btn[0]), .pressed(pr[0]), .released(rl[0]), .is_present(pres[0]),
        .frame_valid(fv[0]), .frame_error(fe[0]), .link_ok(lk[0]));

    gamepad_pmod_multi #(.NUM_PADS(2), .TIMEOUT_CYCLES(TO_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .pmod_data(pmod_data), .pmod_clk(pmod_clk), .pmod_latch(pmod_latch),
        .buttons(btn[1]), .pressed(pr[1]), .released(rl[1]), .is_present(pres[1]),
        .frame_valid(fv[1]), .frame_error(fe[1]), .link_ok(lk[1]));

    always #5 clk = ~clk;

    function automatic logic [1:0] present_of(input logic [23:0] w);
        return {w[23:12] != 12'hFFF, w[11:0] != 12'hFFF};
    endfunction

    function automatic logic [23:0] held_of(input logic [23:0] w);
        return {w[23:12] == 12'hFFF ? 12'h000 : w[23:12], w[11:0] == 12'hFFF ? 12'h000 : w[11:0]};
    endfunction

    function automatic bit due_now();
        return rst_n && q.size() != 0 && q[0].due == cyc + 1;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[dut%0d] cyc=%0d got=%h expected=%h", nm, i, cyc, act, exp);
        end
    endtask

    // frame-level model: commits/errors land 4 bench cycles after the latch is driven,
    // the watchdog clears held state exactly TO cycles after the last commit
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            m_fv[i] <= 1'b0;
            m_fe[i] <= 1'b0;
            m_pr[i] <= '0;
            m_rl[i] <= '0;
            if (!rst_n) begin
                m_btn[i]  <= '0;
                m_pres[i] <= '0;
                m_lk[i]   <= 1'b0;
                m_last[i] <= 0;
            end else if (due_now() && q[0].ok) begin
                m_btn[i]  <= held_of(q[0].word);
                m_pres[i] <= present_of(q[0].word);
                m_pr[i]   <= EV ? held_of(q[0].word) & ~m_btn[i] : 24'h0;
                m_rl[i]   <= EV ? ~held_of(q[0].word) & m_btn[i] : 24'h0;
                m_fv[i]   <= 1'b1;
                m_lk[i]   <= 1'b1;
                m_last[i] <= cyc + 1;
            end else begin
                if (due_now())
                    m_fe[i] <= 1'b1;
                if (m_lk[i] && cyc + 1 - m_last[i] == (i == 0 ? TO_A : TO_B)) begin
                    m_btn[i]  <= '0;
                    m_pres[i] <= '0;
                    m_rl[i]   <= EV ? m_btn[i] : 24'h0;
                    m_lk[i]   <= 1'b0;
                end
            end
        end
        if (!rst_n)
            q.delete();
        else if (due_now())
            void'(q.pop_front());
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk("buttons", i, btn[i], m_btn[i]);
                chk("pressed", i, pr[i], m_pr[i]);
                chk("released", i, rl[i], m_rl[i]);
                chk("is_present", i, pres[i], m_pres[i]);
                chk("frame_valid", i, fv[i], m_fv[i]);
                chk("frame_error", i, fe[i], m_fe[i]);
                chk("link_ok", i, lk[i], m_lk[i]);
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        pmod_data = b;
        pmod_clk  = 1'b1;
        repeat (3) @(negedge clk);
        pmod_clk = 1'b0;
        sr   = {sr[22:0], b};
        bits = bits + 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_bits(input int n, input logic [31:0] v);
        for (int k = n - 1; k >= 0; k--) send_bit(v[k]);
    endtask

    // coinc: the final shift clock fall is driven together with the latch rise and must be lost
    task automatic latch_frame(input bit coinc, input logic b, output int due);
        if (coinc) begin
            pmod_data = b;
            pmod_clk  = 1'b1;
            repeat (3) @(negedge clk);
            pmod_clk = 1'b0;
        end
        pmod_latch = 1'b1;
        due = cyc + 4;
        q.push_back('{due, bits == 24, sr});
        bits = 0;
        wait_until(due);
        pmod_latch = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset.link_ok", 0, lk[0], 0);
        chk("reset.buttons", 1, btn[1], 0);
        chk("reset.is_present", 1, pres[1], 0);

        send_bits(24, 32'hFFF800);
        latch_frame(0, 0, d);
        chk("s1.frame_valid", 1, fv[1], 1);
        chk("s1.buttons", 1, btn[1], 24'h000800);
        chk("s1.is_present", 1, pres[1], 2'b01);
        chk("s1.link_ok", 1, lk[1], 1);
        chk("s1.pressed11", 1, pr[1][11], EV);
        @(negedge clk);
        chk("s1.fv_one_cycle", 1, fv[1], 0);

        send_bits(23, 32'h2AB3C5);
        latch_frame(0, 0, d);
        chk("s2.frame_error23", 1, fe[1], 1);
        chk("s2.frame_valid23", 1, fv[1], 0);
        chk("s2.buttons23", 1, btn[1], 24'h000800);
        send_bits(25, 32'h1234567);
        latch_frame(0, 0, d);
        chk("s2.frame_error25", 1, fe[1], 1);
        chk("s2.buttons25", 1, btn[1], 24'h000800);
        chk("s2.is_present25", 1, pres[1], 2'b01);

        send_bits(24, 32'hFFF800);
        latch_frame(0, 0, d);
        chk("s3.pressed_none", 1, pr[1], 0);
        send_bits(24, 32'hFFF001);
        latch_frame(0, 0, d);
        c = d;
        chk("s3.frame_valid", 1, fv[1], 1);
        chk("s3.released", 1, rl[1], EV ? 24'h000800 : 24'h0);
        chk("s3.pressed", 1, pr[1], EV ? 24'h000001 : 24'h0);
        chk("s3.buttons", 1, btn[1], 24'h000001);

        wait_until(c + TO_A - 1);
        chk("wd.link_before", 0, lk[0], 1);
        chk("wd.buttons_before", 0, btn[0], 24'h000001);
        wait_until(c + TO_A);
        chk("wd.link_after", 0, lk[0], 0);
        chk("wd.buttons_after", 0, btn[0], 0);
        chk("wd.present_after", 0, pres[0], 0);
        chk("wd.released", 0, rl[0], EV ? 24'h000001 : 24'h0);
        chk("wd.frame_valid", 0, fv[0], 0);
        chk("wd.long_link", 1, lk[1], 1);

        send_bits(23, 32'h555555);
        latch_frame(1, 1'b1, d);
        chk("coinc.frame_error", 1, fe[1], 1);
        chk("coinc.buttons", 1, btn[1], 24'h000001);

        send_bits(12, 32'hABC);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst.buttons", i, btn[i], 0);
            chk("rst.is_present", i, pres[i], 0);
            chk("rst.link_ok", i, lk[i], 0);
            chk("rst.frame_valid", i, fv[i], 0);
            chk("rst.frame_error", i, fe[i], 0);
            chk("rst.released", i, rl[i], 0);
        end
        sr   = 0;
        bits = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send_bits(24, 32'hA5C3C3);
        latch_frame(0, 0, d);
        chk("post_rst.buttons", 1, btn[1], 24'hA5C3C3);
        chk("post_rst.is_present", 1, pres[1], 2'b11);
        chk("post_rst.link_ok", 0, lk[0], 1);
        chk("post_rst.pressed", 1, pr[1], EV ? 24'hA5C3C3 : 24'h0);
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
